// File: rtl/intc_banked.sv
// intc_banked -- banked interrupt controller on the local CSR bus.
//
// Up to 16 interrupt sources, grouped in banks of 8. Each bank exposes four
// CSRs at BASE_ADDR + 4*bank + {0: IE, 1: IP (W1C), 2: MODE, 3: POL}.
// Sources are synchronised, polarity-corrected, then detected as an edge
// (MODE=1) or a level (MODE=0) into the pending register. irq is the
// registered OR of (IP & IE) across all banks.
//
// Ports:
//   clk, rst_n     system clock, asynchronous active-low reset
//   csr_a          CSR address (5 bits)
//   csr_di         CSR write data
//   csr_we         one-clk write strobe. The bus has no valid/ready: a write is
//                  taken on the clk edge that samples csr_we high, and a read is
//                  purely combinational (csr_do follows csr_a, no side effects).
//   csr_do         read data, 8'h00 outside this block's address window
//   int_in         raw asynchronous interrupt sources
//   irq            registered interrupt request, active high
module intc_banked #(
  parameter logic [4:0]  BASE_ADDR   = 5'h1c,
  parameter int          NUM_INTS    = 12,
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] DFL_MODE    = 16'hffff
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [4:0]          csr_a,
  input  logic [7:0]          csr_di,
  input  logic                csr_we,
  output logic [7:0]          csr_do,
  input  logic [NUM_INTS-1:0] int_in,
  output logic                irq
);

  localparam int NBANKS = (NUM_INTS + 7) / 8;
  localparam int W      = NBANKS * 8;
  localparam int CW     = $clog2(SYNC_STAGES + 2);

  localparam logic [W-1:0]  VALID_MASK = {W{1'b1}} >> (W - NUM_INTS);
  localparam logic [W-1:0]  MODE_RST   = DFL_MODE[W-1:0] & VALID_MASK;
  localparam logic [CW-1:0] ARM_DONE   = CW'(SYNC_STAGES + 1);

  // Register state
  logic [W-1:0]      ie_q, ie_d;
  logic [W-1:0]      ip_q, ip_d;
  logic [W-1:0]      mode_q, mode_d;
  logic [W-1:0]      pol_q, pol_d;
  logic [W-1:0]      sync_q [SYNC_STAGES];
  logic [W-1:0]      sync_d [SYNC_STAGES];
  logic [W-1:0]      prev_q, prev_d;
  logic [NBANKS-1:0] cfg_wr_q, cfg_wr_d;
  logic [CW-1:0]     arm_cnt_q, arm_cnt_d;
  logic              irq_q, irq_d;

  // Combinational helpers
  logic [4:0]   offset;
  logic [2:0]   bank_idx;
  logic [1:0]   reg_sel;
  logic         in_range;
  logic         armed;
  logic [W-1:0] w1c;
  logic [W-1:0] lvl;
  logic [W-1:0] edge_det;
  logic [W-1:0] supp;
  logic [W-1:0] set_v;

  // Address decode. The subtraction wraps in 5 bits, so addresses below the
  // base land far above 4*NBANKS and are rejected by the same compare.
  always_comb begin
    offset   = csr_a - BASE_ADDR;
    bank_idx = offset[4:2];
    reg_sel  = offset[1:0];
    in_range = ({1'b0, offset} < 6'(4 * NBANKS));
  end

  // Synchroniser chain; unused upper lanes are tied to zero.
  always_comb begin
    sync_d[0] = W'(int_in);
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  // CSR writes and per-bank reconfiguration flag
  always_comb begin
    ie_d     = ie_q;
    mode_d   = mode_q;
    pol_d    = pol_q;
    w1c      = '0;
    cfg_wr_d = '0;
    for (int b = 0; b < NBANKS; b++) begin
      if (csr_we && in_range && (bank_idx == 3'(b))) begin
        case (reg_sel)
          2'd0: ie_d[8*b +: 8] = csr_di;
          2'd1: w1c[8*b +: 8]  = csr_di;
          2'd2: begin
            mode_d[8*b +: 8] = csr_di;
            cfg_wr_d[b]      = 1'b1;
          end
          default: begin
            pol_d[8*b +: 8] = csr_di;
            cfg_wr_d[b]     = 1'b1;
          end
        endcase
      end
    end
    ie_d   = ie_d & VALID_MASK;
    mode_d = mode_d & VALID_MASK;
    pol_d  = pol_d & VALID_MASK;
  end

  // Event detection. A MODE/POL write suppresses its bank in the write clk
  // (cfg_wr_d) and in the following clk (cfg_wr_q), which covers the one clk
  // where lvl already uses the new polarity but prev still holds the old one.
  always_comb begin
    armed    = (arm_cnt_q == ARM_DONE);
    lvl      = (sync_q[SYNC_STAGES-1] ^ pol_q) & VALID_MASK;
    edge_det = lvl & ~prev_q;
    prev_d   = lvl;
    supp     = '0;
    for (int b = 0; b < NBANKS; b++) begin
      supp[8*b +: 8] = {8{cfg_wr_d[b] | cfg_wr_q[b]}};
    end
    set_v = '0;
    if (armed) begin
      set_v = ~supp & ((mode_q & edge_det) | (~mode_q & lvl)) & VALID_MASK;
    end
    // A new event wins over a simultaneous W1C of the same bit.
    ip_d      = set_v | (ip_q & ~w1c);
    irq_d     = |(ip_q & ie_q);
    arm_cnt_d = armed ? arm_cnt_q : arm_cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ie_q      <= '0;
      ip_q      <= '0;
      mode_q    <= MODE_RST;
      pol_q     <= '0;
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      prev_q    <= '0;
      cfg_wr_q  <= '0;
      arm_cnt_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      ie_q      <= ie_d;
      ip_q      <= ip_d;
      mode_q    <= mode_d;
      pol_q     <= pol_d;
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_d[s];
      end
      prev_q    <= prev_d;
      cfg_wr_q  <= cfg_wr_d;
      arm_cnt_q <= arm_cnt_d;
      irq_q     <= irq_d;
    end
  end

  // Combinational read mux
  always_comb begin
    csr_do = 8'h00;
    for (int b = 0; b < NBANKS; b++) begin
      if (in_range && (bank_idx == 3'(b))) begin
        case (reg_sel)
          2'd0:    csr_do = ie_q[8*b +: 8];
          2'd1:    csr_do = ip_q[8*b +: 8];
          2'd2:    csr_do = mode_q[8*b +: 8];
          default: csr_do = pol_q[8*b +: 8];
        endcase
      end
    end
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_intc_banked.sv
// Testbench for intc_banked (12 sources, two banks, 2 sync stages).
// The block is placed at base 0x10 so both banks fit inside the 5-bit
// address space: bank0 = 0x10..0x13, bank1 = 0x14..0x17.
module tb_intc_banked;

  localparam int NI = 12;

  localparam logic [4:0] A_IE0   = 5'h10;
  localparam logic [4:0] A_IP0   = 5'h11;
  localparam logic [4:0] A_MODE0 = 5'h12;
  localparam logic [4:0] A_POL0  = 5'h13;
  localparam logic [4:0] A_IP1   = 5'h15;
  localparam logic [4:0] A_MODE1 = 5'h16;
  localparam logic [4:0] A_IE1   = 5'h14;

  logic          clk;
  logic          rst_n;
  logic [4:0]    csr_a;
  logic [7:0]    csr_di;
  logic          csr_we;
  logic [7:0]    csr_do;
  logic [NI-1:0] int_in;
  logic          irq;

  int checks;
  int failures;

  logic [7:0] exp_q[$];

  typedef struct {
    logic [4:0] addr;
    bit         wr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs [NV];

  intc_banked #(
    .BASE_ADDR  (5'h10),
    .NUM_INTS   (NI),
    .SYNC_STAGES(2),
    .DFL_MODE   (16'hffff)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .csr_a (csr_a),
    .csr_di(csr_di),
    .csr_we(csr_we),
    .csr_do(csr_do),
    .int_in(int_in),
    .irq   (irq)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  // Driver tasks: each starts and ends 1 ns after a rising edge and takes one clk.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%02h exp=%02h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    csr_a  = a;
    csr_di = d;
    csr_we = 1'b1;
    step();
    csr_we = 1'b0;
  endtask

  // Expected value is queued when the read is driven and popped when csr_do is sampled.
  task automatic rd_chk(input logic [4:0] a, input logic [7:0] exp, input string tag);
    logic [7:0] e;
    exp_q.push_back(exp);
    csr_a = a;
    #2;
    e = exp_q.pop_front();
    chk(tag, csr_do, e);
    step();
  endtask

  task automatic chk_irq(input logic exp, input string tag);
    chk(tag, {7'b0, irq}, {7'b0, exp});
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    vecs[0]  = '{5'h10, 1'b0, 8'h00, 8'h00};
    vecs[1]  = '{5'h11, 1'b0, 8'h00, 8'h00};
    vecs[2]  = '{5'h12, 1'b0, 8'h00, 8'hff};
    vecs[3]  = '{5'h13, 1'b0, 8'h00, 8'h00};
    vecs[4]  = '{5'h14, 1'b0, 8'h00, 8'h00};
    vecs[5]  = '{5'h15, 1'b0, 8'h00, 8'h00};
    vecs[6]  = '{5'h16, 1'b0, 8'h00, 8'h0f};
    vecs[7]  = '{5'h17, 1'b0, 8'h00, 8'h00};
    vecs[8]  = '{5'h0f, 1'b0, 8'h00, 8'h00};
    vecs[9]  = '{5'h18, 1'b0, 8'h00, 8'h00};
    vecs[10] = '{5'h00, 1'b0, 8'h00, 8'h00};
    vecs[11] = '{5'h1f, 1'b0, 8'h00, 8'h00};
    vecs[12] = '{5'h14, 1'b1, 8'hff, 8'h0f};
    vecs[13] = '{5'h16, 1'b1, 8'h30, 8'h00};
    vecs[14] = '{5'h16, 1'b1, 8'h0f, 8'h0f};
    vecs[15] = '{5'h17, 1'b1, 8'hf5, 8'h05};
    vecs[16] = '{5'h17, 1'b1, 8'h00, 8'h00};
    vecs[17] = '{5'h15, 1'b0, 8'h00, 8'h00};
    vecs[18] = '{5'h10, 1'b1, 8'ha5, 8'ha5};
    vecs[19] = '{5'h12, 1'b1, 8'h5a, 8'h5a};
    vecs[20] = '{5'h12, 1'b1, 8'hff, 8'hff};
    vecs[21] = '{5'h10, 1'b1, 8'h00, 8'h00};
    vecs[22] = '{5'h18, 1'b1, 8'hff, 8'h00};
    vecs[23] = '{5'h11, 1'b1, 8'hff, 8'h00};
    vecs[24] = '{5'h14, 1'b0, 8'h00, 8'h0f};

    // Reset
    rst_n  = 1'b1;
    csr_a  = 5'h00;
    csr_di = 8'h00;
    csr_we = 1'b0;
    int_in = '0;
    #2 rst_n = 1'b0;
    repeat (3) step();
    chk_irq(1'b0, "irq_in_reset");
    rst_n = 1'b1;

    // Pulse inside the arm window must not pend
    int_in[0] = 1'b1;
    step();
    int_in[0] = 1'b0;
    repeat (6) step();
    rd_chk(A_IP0, 8'h00, "arm_window_ip0");
    chk_irq(1'b0, "arm_window_irq");

    // Register map table
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].wr) wr(vecs[i].addr, vecs[i].wdata);
      rd_chk(vecs[i].addr, vecs[i].exp, $sformatf("vec%0d_a%02h", i, vecs[i].addr));
    end

    // Edge: IP at +3 clks, irq at +4 clks, W1C drops irq two clks later
    wr(A_IE0, 8'h01);
    int_in[0] = 1'b1;
    repeat (2) step();
    rd_chk(A_IP0, 8'h00, "edge_ip_early");
    chk_irq(1'b0, "edge_irq_early");
    rd_chk(A_IP0, 8'h01, "edge_ip_set");
    chk_irq(1'b1, "edge_irq_set");
    wr(A_IP0, 8'h01);
    chk_irq(1'b1, "w1c_irq_lag");
    step();
    chk_irq(1'b0, "w1c_irq_clear");
    rd_chk(A_IP0, 8'h00, "w1c_ip_clear");

    // Level mode on channel 3
    wr(A_MODE0, 8'hf7);
    int_in[3] = 1'b1;
    repeat (4) step();
    rd_chk(A_IP0, 8'h08, "level_ip_set");
    wr(A_IP0, 8'h08);
    rd_chk(A_IP0, 8'h08, "level_w1c_active");
    chk_irq(1'b0, "level_irq_masked");
    int_in[3] = 1'b0;
    repeat (4) step();
    rd_chk(A_IP0, 8'h08, "level_ip_held");
    wr(A_IP0, 8'h08);
    rd_chk(A_IP0, 8'h00, "level_w1c_inactive");
    wr(A_MODE0, 8'hff);

    // Polarity on channels 1 and 2
    int_in[1] = 1'b1;
    repeat (4) step();
    rd_chk(A_IP0, 8'h02, "pol0_rise");
    wr(A_IP0, 8'h02);
    rd_chk(A_IP0, 8'h00, "pol0_w1c");
    wr(A_POL0, 8'h06);
    repeat (4) step();
    rd_chk(A_IP0, 8'h00, "pol_write_no_event");
    rd_chk(A_POL0, 8'h06, "pol_readback");
    int_in[1] = 1'b0;
    repeat (4) step();
    rd_chk(A_IP0, 8'h02, "pol1_fall");
    wr(A_IP0, 8'h02);
    wr(A_POL0, 8'h00);
    repeat (4) step();
    rd_chk(A_IP0, 8'h00, "pol_restore");

    // Collision: W1C lands on the same clk as a new channel-0 event
    int_in[0] = 1'b0;
    repeat (4) step();
    int_in[0] = 1'b1;
    repeat (2) step();
    wr(A_IP0, 8'h01);
    rd_chk(A_IP0, 8'h01, "collision_set_wins");
    chk_irq(1'b1, "collision_irq");
    wr(A_IP0, 8'h01);
    step();
    chk_irq(1'b0, "collision_irq_clear");
    rd_chk(A_IP0, 8'h00, "collision_ip_clear");

    // Bank 1, channel 10
    int_in[10] = 1'b1;
    repeat (2) step();
    rd_chk(A_IP1, 8'h00, "bank1_ip_early");
    rd_chk(A_IP1, 8'h04, "bank1_ip_set");
    chk_irq(1'b1, "bank1_irq");

    // Asynchronous reset mid-run
    #2 rst_n = 1'b0;
    #1;
    chk_irq(1'b0, "async_reset_irq");
    step();
    rst_n = 1'b1;
    rd_chk(A_IE1, 8'h00, "post_reset_ie1");
    rd_chk(A_IP1, 8'h00, "post_reset_ip1");
    rd_chk(A_MODE1, 8'h0f, "post_reset_mode1");
    chk_irq(1'b0, "post_reset_irq");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
